im_boot_ctrl: RTL
=================

// Module: im_boot_ctrl
// PURPOSE
//  Sequencer for the instruction memory. Drains a program image from an upstream FIFO into the IM write
//  port at consecutive byte addresses, detects the end-of-image flag, then raises PCstart to release the CPU.
//  After boot it shares the single IM read port between CPU fetch and a debug readback requester.
//  Sits between the boot FIFO, the IM and the CPU fetch stage; it replaces free-running write-address counting.
// PARAMETERS
//  BASE_ADDR  32'h0000_0000  byte address of the first image word
//  MAX_WORDS  1024           image words accepted before overflow error
//  TIMEOUT    65535          consecutive FIFO-empty cycles in LOAD before timeout error
// PORTS
//  clk         in   1   single clock, all logic on posedge
//  RST         in   1   reset, synchronous, active-high
//  START       in   1   begin load; sampled only in IDLE
//  FIFO_EMPTY  in   1   upstream FIFO empty
//  FIFO_RDEN   out  1   FIFO pop; data valid on FIFO_DATA the following cycle
//  FIFO_DATA   in   33  [32]=last-word flag, [31:0]=instruction
//  IM_VALIDin  out  1   IM write strobe
//  IM_WRaddr   out  32  IM write byte address
//  IM_WRdata   out  33  IM write data, flag bit passed through
//  IM_RDaddr   out  32  muxed IM read address
//  IM_VALIDout in   1   IM read data valid (IM read latency 1)
//  IM_RDdata   in   32  IM read data
//  CPU_RDREQ   in   1   CPU fetch request
//  CPU_RDaddr  in   32  CPU fetch address
//  CPU_VALID   out  1   fetch data valid
//  CPU_RDdata  out  32  fetch data
//  DBG_REQ     in   1   debug read request
//  DBG_RDaddr  in   32  debug read address
//  DBG_GNT     out  1   debug request accepted this cycle
//  DBG_VALID   out  1   debug data valid
//  DBG_RDdata  out  32  debug data
//  PCstart     out  1   level; high in RUN only
//  BUSY        out  1   high in LOAD
//  ERR         out  1   high in ERR
//  WORDcount   out  11  words written this load (clog2(MAX_WORDS)+1)
// BEHAVIOUR
//  Reset: state=IDLE; every output 0, including WORDcount, timeout counter and the read-owner flag. IM contents untouched.
//  FSM: IDLE -START-> LOAD; LOAD -last word written-> RUN; LOAD -overflow|timeout-> ERR; RUN and ERR hold until RST.
//  LOAD: FIFO_RDEN = !FIFO_EMPTY && !last_seen && !pop_pending_overflow. One pop every cycle while data is present.
//   Cycle after a pop: IM_VALIDin=1, IM_WRaddr=BASE_ADDR+4*WORDcount, IM_WRdata=FIFO_DATA; WORDcount++.
//   FIFO_DATA[32]=1: set last_seen, no further pops; the next cycle enters RUN, PCstart=1.
//   A single word with the flag set is a valid 1-word image.
//   Write number MAX_WORDS without the flag -> ERR; the pop that would exceed MAX_WORDS is never issued.
//   Exactly MAX_WORDS words with the flag on the last one -> RUN.
//   Timeout counter: increments each LOAD cycle with FIFO_EMPTY=1 and no pop pending, clears on any pop.
//    Count == TIMEOUT -> ERR.
//  START outside IDLE is ignored. RST mid-LOAD aborts at once: no further IM writes; a pending FIFO word is dropped.
//  Read arbitration: fixed priority, CPU over DBG.
//   CPU is served only in RUN; DBG is served in IDLE, RUN and ERR, never in LOAD.
//   Grant cycle: IM_RDaddr=winner address. DBG_GNT=1 the same cycle when DBG wins.
//    Winner is registered in a 1-bit owner flag.
//   IM_VALIDout the next cycle is steered by the owner flag to CPU_VALID/CPU_RDdata or DBG_VALID/DBG_RDdata.
//    The other valid stays 0. The *_RDdata outputs hold their last value.
//   Both requesting every cycle in RUN -> DBG starves. This is intended.
//  Width: address add in 32 bits, wraps modulo 2^32. WORDcount saturates at MAX_WORDS.
// STRUCTURE
//  Package im_boot_pkg: state enum (IDLE=2'd0, LOAD=2'd1, RUN=2'd2, ERR=2'd3) and the FLAG_BIT=32 constant.
//  Sub-module im_rd_arb: priority select, owner flag, return steering.
//  The FSM, counters and FIFO handshake stay in im_boot_ctrl.
// TESTING
//  1) RST, START, FIFO holds 3 words, the last with [32]=1 -> writes at 0x0,0x4,0x8; WORDcount=3; PCstart=1 one cycle after the 3rd write.
//  2) FIFO empties after 2 words for TIMEOUT cycles (bench TIMEOUT=16) -> ERR=1 on cycle 16; PCstart stays 0; no 3rd write.
//  3) MAX_WORDS=4, 6 words with no flag -> exactly 4 writes, ERR=1, FIFO_RDEN never asserted for word 5.
//  4) RUN, CPU_RDREQ=1 and DBG_REQ=1 with addr 0x8 and 0x10 -> IM_RDaddr=0x8, DBG_GNT=0.
//     Next cycle CPU_VALID=1, DBG_VALID=0. CPU drops -> DBG_GNT=1 with IM_RDaddr=0x10.
//  5) RST asserted mid-LOAD after 2 writes -> next cycle IDLE, all outputs 0. Restart with START reloads from BASE_ADDR.
//  6) START while in RUN -> no state change, FIFO_RDEN stays 0.

Source files
------------

// File: rtl/im_boot_pkg.sv
`default_nettype none
// ============================================================================
// Module      : im_boot_pkg
// Description : Shared types and constants for the instruction-memory boot
//               sequencer and its read arbiter.
// Revision    : 1.0  initial release
// ============================================================================
package im_boot_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    localparam int unsigned FLAG_BIT = 32;

endpackage
`default_nettype wire

// File: rtl/im_rd_arb.sv
`default_nettype none
// ============================================================================
// Module      : im_rd_arb
// Description : Fixed-priority (CPU over debug) sharing of the single IM read
//               port, with a one-bit owner flag steering the returned data.
// Revision    : 1.0  initial release
// ============================================================================
module im_rd_arb (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_cpu_en,
    input  logic        i_dbg_en,
    input  logic        i_cpu_req,
    input  logic [31:0] i_cpu_addr,
    input  logic        i_dbg_req,
    input  logic [31:0] i_dbg_addr,
    input  logic        i_im_valid,
    input  logic [31:0] i_im_data,
    output logic [31:0] o_im_addr,
    output logic        o_dbg_gnt,
    output logic        o_cpu_valid,
    output logic [31:0] o_cpu_data,
    output logic        o_dbg_valid,
    output logic [31:0] o_dbg_data
);

    logic        w_cpu_win;
    logic        w_dbg_win;
    logic        w_cpu_valid;
    logic        w_dbg_valid;
    logic        r_owner_dbg;
    logic [31:0] r_cpu_data;
    logic [31:0] r_dbg_data;

    assign w_cpu_win = i_cpu_en & i_cpu_req;
    assign w_dbg_win = i_dbg_en & i_dbg_req & ~w_cpu_win;

    always_comb begin
        o_im_addr = '0;
        if (w_cpu_win) begin
            o_im_addr = i_cpu_addr;
        end else if (w_dbg_win) begin
            o_im_addr = i_dbg_addr;
        end
    end

    // IM read latency is one cycle, so the owner recorded at grant matches the returning data
    assign w_cpu_valid = i_im_valid & ~r_owner_dbg;
    assign w_dbg_valid = i_im_valid &  r_owner_dbg;

    assign o_dbg_gnt   = w_dbg_win;
    assign o_cpu_valid = w_cpu_valid;
    assign o_dbg_valid = w_dbg_valid;
    assign o_cpu_data  = w_cpu_valid ? i_im_data : r_cpu_data;
    assign o_dbg_data  = w_dbg_valid ? i_im_data : r_dbg_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner_dbg <= 1'b0;
            r_cpu_data  <= '0;
            r_dbg_data  <= '0;
        end else begin
            if (w_cpu_win) begin
                r_owner_dbg <= 1'b0;
            end else if (w_dbg_win) begin
                r_owner_dbg <= 1'b1;
            end
            if (w_cpu_valid) begin
                r_cpu_data <= i_im_data;
            end
            if (w_dbg_valid) begin
                r_dbg_data <= i_im_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/im_boot_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : im_boot_ctrl
// Description : Drains a program image from the boot FIFO into the IM, then
//               releases the CPU and shares the IM read port with debug.
// Revision    : 1.0  initial release
// ============================================================================
module im_boot_ctrl
    import im_boot_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 1024,
    parameter int unsigned TIMEOUT   = 65535,
    localparam int unsigned WC_W     = $clog2(MAX_WORDS) + 1
) (
    input  logic            clk,
    input  logic            RST,
    input  logic            START,
    input  logic            FIFO_EMPTY,
    output logic            FIFO_RDEN,
    input  logic [32:0]     FIFO_DATA,
    output logic            IM_VALIDin,
    output logic [31:0]     IM_WRaddr,
    output logic [32:0]     IM_WRdata,
    output logic [31:0]     IM_RDaddr,
    input  logic            IM_VALIDout,
    input  logic [31:0]     IM_RDdata,
    input  logic            CPU_RDREQ,
    input  logic [31:0]     CPU_RDaddr,
    output logic            CPU_VALID,
    output logic [31:0]     CPU_RDdata,
    input  logic            DBG_REQ,
    input  logic [31:0]     DBG_RDaddr,
    output logic            DBG_GNT,
    output logic            DBG_VALID,
    output logic [31:0]     DBG_RDdata,
    output logic            PCstart,
    output logic            BUSY,
    output logic            ERR,
    output logic [WC_W-1:0] WORDcount
);

    localparam int unsigned TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_t          r_state;
    state_t          w_next;
    logic            r_pop_pend;
    logic [WC_W-1:0] r_word_cnt;
    logic [TO_W-1:0] r_to_cnt;

    logic w_load;
    logic w_wr;
    logic w_last;
    logic w_room;
    logic w_pop;
    logic w_ovf;
    logic w_idle_tick;
    logic w_to_hit;

    assign w_load = (r_state == ST_LOAD);
    assign w_wr   = w_load & r_pop_pend;
    assign w_last = w_wr & FIFO_DATA[FLAG_BIT];

    // Words already written plus the one in flight must stay below the cap before popping again
    assign w_room = (32'(r_word_cnt) + 32'(r_pop_pend)) < MAX_WORDS;
    assign w_pop  = w_load & ~FIFO_EMPTY & ~w_last & w_room;

    assign w_ovf       = w_wr & ~FIFO_DATA[FLAG_BIT] & (32'(r_word_cnt) == MAX_WORDS - 1);
    assign w_idle_tick = w_load & FIFO_EMPTY & ~r_pop_pend;
    assign w_to_hit    = w_idle_tick & (32'(r_to_cnt) == TIMEOUT - 1);

    always_ff @(posedge clk) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (START) begin
                    w_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_last) begin
                    w_next = ST_RUN;
                end else if (w_ovf || w_to_hit) begin
                    w_next = ST_ERR;
                end
            end
            default: w_next = r_state;
        endcase
    end

    always_comb begin
        FIFO_RDEN  = w_pop;
        IM_VALIDin = w_wr;
        IM_WRaddr  = '0;
        IM_WRdata  = '0;
        if (w_wr) begin
            IM_WRaddr = BASE_ADDR + (32'(r_word_cnt) << 2);
            IM_WRdata = FIFO_DATA;
        end
        PCstart = (r_state == ST_RUN);
        BUSY    = (r_state == ST_LOAD);
        ERR     = (r_state == ST_ERR);
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            r_pop_pend <= 1'b0;
            r_word_cnt <= '0;
            r_to_cnt   <= '0;
        end else begin
            r_pop_pend <= w_pop;
            if ((r_state == ST_IDLE) && START) begin
                r_word_cnt <= '0;
            end else if (w_wr && (32'(r_word_cnt) < MAX_WORDS)) begin
                r_word_cnt <= r_word_cnt + WC_W'(1);
            end
            if (w_pop || ((r_state == ST_IDLE) && START)) begin
                r_to_cnt <= '0;
            end else if (w_idle_tick) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end
        end
    end

    assign WORDcount = r_word_cnt;

    im_rd_arb u_rd_arb (
        .clk         (clk),
        .rst         (RST),
        .i_cpu_en    (r_state == ST_RUN),
        .i_dbg_en    (r_state != ST_LOAD),
        .i_cpu_req   (CPU_RDREQ),
        .i_cpu_addr  (CPU_RDaddr),
        .i_dbg_req   (DBG_REQ),
        .i_dbg_addr  (DBG_RDaddr),
        .i_im_valid  (IM_VALIDout),
        .i_im_data   (IM_RDdata),
        .o_im_addr   (IM_RDaddr),
        .o_dbg_gnt   (DBG_GNT),
        .o_cpu_valid (CPU_VALID),
        .o_cpu_data  (CPU_RDdata),
        .o_dbg_valid (DBG_VALID),
        .o_dbg_data  (DBG_RDdata)
    );

endmodule
`default_nettype wire
